demux1a4_rx: RTL and testbench



---
 rtl/demux_pkg.sv | 27 ++
 rtl/demux1a4_rx_if.sv | 43 ++++
 rtl/demux_lane_ctr.sv | 43 ++++
 rtl/demux1a4_rx.sv | 82 ++++++++
 tb/tb_demux1a4_rx.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/demux_pkg.sv
// Shared types for the 1:4 receive demultiplexer: lane index and, with
// DEMUX1A4_PARITY_EN defined, the per-byte even-parity checker.
package demux_pkg;

  localparam int LANES = 4;
  localparam int CNT_W = 2;

  typedef enum logic [CNT_W-1:0] {
    LANE0 = 2'd0,
    LANE1 = 2'd1,
    LANE2 = 2'd2,
    LANE3 = 2'd3
  } lane_idx_t;

`ifdef DEMUX1A4_PARITY_EN
  // Returns 1 when bit [width] is not the even-parity bit of data[width-1:0].
  function automatic logic parity_bad(input logic [63:0] data, input int unsigned width);
    logic p;
    p = data[width];
    for (int i = 0; i < 64; i++) begin
      if (i < width) p = p ^ data[i];
    end
    return p;
  endfunction
`endif

endpackage

// File: rtl/demux1a4_rx_if.sv
// Serial-in / 4-lane-out bundle of demux1a4_rx; gains parity_err and a
// widened data_in when DEMUX1A4_PARITY_EN is defined.
interface demux1a4_rx_if #(parameter int WIDTH = 8);

`ifdef DEMUX1A4_PARITY_EN
  localparam int DIN_W = WIDTH + 1;
`else
  localparam int DIN_W = WIDTH;
`endif

  logic             valid_in;
  logic [DIN_W-1:0] data_in;
  logic             flush;
  logic [WIDTH-1:0] lane0_out;
  logic [WIDTH-1:0] lane1_out;
  logic [WIDTH-1:0] lane2_out;
  logic [WIDTH-1:0] lane3_out;
  logic             valid_out;
  logic             busy;

`ifdef DEMUX1A4_PARITY_EN
  logic             parity_err;

  modport master (
    output valid_in, data_in, flush,
    input  lane0_out, lane1_out, lane2_out, lane3_out, valid_out, busy, parity_err
  );
  modport slave (
    input  valid_in, data_in, flush,
    output lane0_out, lane1_out, lane2_out, lane3_out, valid_out, busy, parity_err
  );
`else
  modport master (
    output valid_in, data_in, flush,
    input  lane0_out, lane1_out, lane2_out, lane3_out, valid_out, busy
  );
  modport slave (
    input  valid_in, data_in, flush,
    output lane0_out, lane1_out, lane2_out, lane3_out, valid_out, busy
  );
`endif

endinterface

// File: rtl/demux_lane_ctr.sv
// Lane pointer for the receive demultiplexer: walks LANE0..LANE3 on each
// accepted byte, returns to LANE0 on flush or wrap.
module demux_lane_ctr
  import demux_pkg::*;
(
  input  logic      C,
  input  logic      R,
  input  logic      flush,
  input  logic      advance,
  output lane_idx_t cnt,
  output logic      last
);

  lane_idx_t cnt_nxt;

  // NOTE: state registers take non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge C) begin
    if (R) cnt <= LANE0;
    else   cnt <= cnt_nxt;
  end

  // NOTE: the hold default comes first so no path through this block leaves
  // cnt_nxt unassigned, which would otherwise infer a latch.
  always_comb begin
    cnt_nxt = cnt;
    if (flush) begin
      cnt_nxt = LANE0;
    end else if (advance) begin
      case (cnt)
        LANE0:   cnt_nxt = LANE1;
        LANE1:   cnt_nxt = LANE2;
        LANE2:   cnt_nxt = LANE3;
        default: cnt_nxt = LANE0;
      endcase
    end
  end

  always_comb begin
    last = (cnt == LANE3);
  end

endmodule

// File: rtl/demux1a4_rx.sv
// 1:4 receive demultiplexer: stages three bytes, then emits the 4-lane word
// with a one-cycle strobe. DEMUX1A4_PARITY_EN adds per-word parity checking.
module demux1a4_rx
  import demux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LANES = 4
) (
  input logic           C,
  input logic           R,
  demux1a4_rx_if.slave  bus
);

  lane_idx_t        cnt;
  logic             last;
  logic             accept;
  logic [WIDTH-1:0] byte_in;
  logic [WIDTH-1:0] stage  [LANES-1];
  logic [WIDTH-1:0] lane_q [LANES];
  logic             valid_q;

  // flush wins over valid_in, so a byte arriving with flush is dropped.
  assign accept  = bus.valid_in & ~bus.flush;
  assign byte_in = bus.data_in[WIDTH-1:0];

  demux_lane_ctr u_ctr (
    .C       (C),
    .R       (R),
    .flush   (bus.flush),
    .advance (accept),
    .cnt     (cnt),
    .last    (last)
  );

  always_ff @(posedge C) begin
    if (R) begin
      // NOTE: the staging array is cleared explicitly; arrays are not reset
      // by default, and here every register must read zero after reset.
      for (int i = 0; i < LANES - 1; i++) stage[i] <= '0;
      for (int i = 0; i < LANES; i++)     lane_q[i] <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= accept & last;
      if (accept && !last) stage[cnt] <= byte_in;
      // The final byte bypasses staging and lands with the other three.
      if (accept && last) begin
        for (int i = 0; i < LANES - 1; i++) lane_q[i] <= stage[i];
        lane_q[LANES-1] <= byte_in;
      end
    end
  end

`ifdef DEMUX1A4_PARITY_EN
  logic byte_bad;
  logic err_acc;
  logic parity_q;

  assign byte_bad = parity_bad(64'(bus.data_in), WIDTH);

  // err_acc collects errors of the partial word; parity_q reports the word.
  always_ff @(posedge C) begin
    if (R) begin
      err_acc  <= 1'b0;
      parity_q <= 1'b0;
    end else begin
      parity_q <= accept & last & (err_acc | byte_bad);
      if (bus.flush || (accept && last)) err_acc <= 1'b0;
      else if (accept)                   err_acc <= err_acc | byte_bad;
    end
  end

  assign bus.parity_err = parity_q;
`endif

  assign bus.lane0_out = lane_q[0];
  assign bus.lane1_out = lane_q[1];
  assign bus.lane2_out = lane_q[2];
  assign bus.lane3_out = lane_q[3];
  assign bus.valid_out = valid_q;
  assign bus.busy      = (cnt != LANE0);

endmodule

// File: tb/tb_demux1a4_rx.sv
// Directed bench for demux1a4_rx: word assembly, gaps, flush, reset, and the
// parity path when DEMUX1A4_PARITY_EN is defined.
module tb_demux1a4_rx;

  localparam int WIDTH = 8;

  logic C;
  logic R;
  int   checks = 0;
  int   errors = 0;

  demux1a4_rx_if #(.WIDTH(WIDTH)) bus ();

  demux1a4_rx #(.WIDTH(WIDTH), .LANES(4)) dut (
    .C   (C),
    .R   (R),
    .bus (bus)
  );

  initial C = 1'b0;
  always #5 C = ~C;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_word(input string tag, input logic [7:0] w0, input logic [7:0] w1,
                            input logic [7:0] w2, input logic [7:0] w3);
    check({tag, ".lane0"}, 32'(bus.lane0_out), 32'(w0));
    check({tag, ".lane1"}, 32'(bus.lane1_out), 32'(w1));
    check({tag, ".lane2"}, 32'(bus.lane2_out), 32'(w2));
    check({tag, ".lane3"}, 32'(bus.lane3_out), 32'(w3));
  endtask

  // Drive one cycle of input, then settle 1 time unit past the rising edge.
  task automatic tick(input logic v, input logic [7:0] b, input logic f);
    bus.valid_in = v;
    bus.flush    = f;
`ifdef DEMUX1A4_PARITY_EN
    bus.data_in  = {^b, b};
`else
    bus.data_in  = b;
`endif
    @(posedge C);
    #1;
  endtask

`ifdef DEMUX1A4_PARITY_EN
  task automatic tick_bad(input logic [7:0] b);
    bus.valid_in = 1'b1;
    bus.flush    = 1'b0;
    bus.data_in  = {~(^b), b};
    @(posedge C);
    #1;
  endtask
`endif

  initial begin
    R = 1'b1;
    bus.valid_in = 1'b0;
    bus.flush    = 1'b0;
    bus.data_in  = '0;
    tick(0, 8'h00, 0);
    tick(0, 8'h00, 0);
    check_word("reset", 8'h00, 8'h00, 8'h00, 8'h00);
    check("reset.valid", 32'(bus.valid_out), 32'd0);
    check("reset.busy",  32'(bus.busy), 32'd0);
    R = 1'b0;

    // Back-to-back word
    tick(1, 8'hA1, 0);
    check("b2b.busy1", 32'(bus.busy), 32'd1);
    check("b2b.valid1", 32'(bus.valid_out), 32'd0);
    tick(1, 8'hB2, 0);
    tick(1, 8'hC3, 0);
    check("b2b.valid3", 32'(bus.valid_out), 32'd0);
    check_word("b2b.pre", 8'h00, 8'h00, 8'h00, 8'h00);
    tick(1, 8'hD4, 0);
    check_word("b2b", 8'hA1, 8'hB2, 8'hC3, 8'hD4);
    check("b2b.valid", 32'(bus.valid_out), 32'd1);
    check("b2b.busy",  32'(bus.busy), 32'd0);
    tick(0, 8'h00, 0);
    check("b2b.strobe_end", 32'(bus.valid_out), 32'd0);

    // Same bytes with two idle cycles between each
    tick(1, 8'hA1, 0); tick(0, 8'hFF, 0); tick(0, 8'hFF, 0);
    tick(1, 8'hB2, 0); tick(0, 8'hFF, 0);
    check("gap.busy_hold", 32'(bus.busy), 32'd1);
    tick(0, 8'hFF, 0);
    tick(1, 8'hC3, 0); tick(0, 8'hFF, 0); tick(0, 8'hFF, 0);
    check("gap.valid_idle", 32'(bus.valid_out), 32'd0);
    tick(1, 8'hD4, 0);
    check_word("gap", 8'hA1, 8'hB2, 8'hC3, 8'hD4);
    check("gap.valid", 32'(bus.valid_out), 32'd1);
    tick(0, 8'h00, 0);
    check("gap.strobe_end", 32'(bus.valid_out), 32'd0);

    // Flush mid-word
    tick(1, 8'h11, 0);
    tick(1, 8'h22, 0);
    tick(0, 8'h00, 1);
    check("flush.busy", 32'(bus.busy), 32'd0);
    check_word("flush.hold", 8'hA1, 8'hB2, 8'hC3, 8'hD4);
    tick(1, 8'h33, 0);
    tick(1, 8'h44, 0);
    tick(1, 8'h55, 0);
    check_word("flush.hold2", 8'hA1, 8'hB2, 8'hC3, 8'hD4);
    tick(1, 8'h66, 0);
    check_word("flush.word", 8'h33, 8'h44, 8'h55, 8'h66);
    check("flush.valid", 32'(bus.valid_out), 32'd1);

    // Flush together with the 4th byte
    tick(1, 8'h77, 0);
    tick(1, 8'h88, 0);
    tick(1, 8'h99, 0);
    check("f4.busy_pre", 32'(bus.busy), 32'd1);
    tick(1, 8'hAA, 1);
    check("f4.valid", 32'(bus.valid_out), 32'd0);
    check("f4.busy",  32'(bus.busy), 32'd0);
    check_word("f4.hold", 8'h33, 8'h44, 8'h55, 8'h66);
    tick(1, 8'h01, 0);
    tick(1, 8'h02, 0);
    tick(1, 8'h03, 0);
    tick(1, 8'h04, 0);
    check_word("f4.next", 8'h01, 8'h02, 8'h03, 8'h04);
    check("f4.next_valid", 32'(bus.valid_out), 32'd1);

    // Reset after three bytes while valid_in stays high
    tick(1, 8'h10, 0);
    tick(1, 8'h20, 0);
    tick(1, 8'h30, 0);
    R = 1'b1;
    tick(1, 8'h40, 0);
    check_word("rst3", 8'h00, 8'h00, 8'h00, 8'h00);
    check("rst3.valid", 32'(bus.valid_out), 32'd0);
    check("rst3.busy",  32'(bus.busy), 32'd0);
    R = 1'b0;
    tick(1, 8'hE1, 0);
    tick(1, 8'hE2, 0);
    tick(1, 8'hE3, 0);
    tick(1, 8'hE4, 0);
    check_word("rst3.next", 8'hE1, 8'hE2, 8'hE3, 8'hE4);
    check("rst3.next_valid", 32'(bus.valid_out), 32'd1);

`ifdef DEMUX1A4_PARITY_EN
    // Byte 2 carries a flipped parity bit
    tick(1, 8'hA1, 0);
    tick(1, 8'hB2, 0);
    tick_bad(8'hC3);
    tick(1, 8'hD4, 0);
    check("par.valid", 32'(bus.valid_out), 32'd1);
    check("par.err",   32'(bus.parity_err), 32'd1);
    check_word("par.word", 8'hA1, 8'hB2, 8'hC3, 8'hD4);
    tick(1, 8'h5A, 0);
    tick(1, 8'h6B, 0);
    tick(1, 8'h7C, 0);
    tick(1, 8'h8D, 0);
    check("par.clean_valid", 32'(bus.valid_out), 32'd1);
    check("par.clean_err",   32'(bus.parity_err), 32'd0);
`endif

    tick(0, 8'h00, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
